// File: rtl/instr_fetch.sv
// instr_fetch: fetch stage. Owns the PC, issues word reads to instruction memory and
// buffers returned words with their addresses in a DEPTH-entry FIFO for decode.
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   imem_req/imem_addr/imem_ready    request channel (req & ready = issue)
//   imem_rvalid/imem_rdata           in-order responses, one per issued request
//   redirect_valid/redirect_pc       PC redirect from execute; flushes wrong-path words
//   instr_valid/instr_ready          handshake to decode (valid & ready = pop)
//   instr/instr_pc                   head-of-FIFO instruction word and its address
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) return '0;
    return p + PW'(1);
  endfunction

  // Architectural state
  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [PW-1:0] fifo_head_q, fifo_head_d;
  logic [PW-1:0] fifo_tail_q, fifo_tail_d;
  logic [PW-1:0] infl_head_q, infl_head_d;
  logic [PW-1:0] infl_tail_q, infl_tail_d;

  // Storage: FIFO payload and the PC of each request still in flight
  logic [31:0] fifo_word_q [DEPTH];
  logic [31:0] fifo_pc_q   [DEPTH];
  logic [31:0] infl_pc_q   [DEPTH];

  logic [CW:0] in_use;
  logic        issue;
  logic        resp_drop;
  logic        resp_keep;
  logic        pop;
  logic        unused_redirect_lsb;

  assign unused_redirect_lsb = ^redirect_pc[1:0];

  // Buffered words plus in-flight requests bound the credit for new requests,
  // so every response is guaranteed a FIFO slot when it lands.
  assign in_use    = {1'b0, count_q} + {1'b0, outstanding_q};
  assign imem_req  = rst_n && !redirect_valid && (in_use < DEPTH_W);
  assign imem_addr = pc_q;
  assign issue     = imem_req && imem_ready;

  // A response is wrong-path if older redirects still owe discards or if a
  // redirect arrives in the same cycle.
  assign resp_drop = imem_rvalid && (redirect_valid || (drop_q != '0));
  assign resp_keep = imem_rvalid && !resp_drop;

  assign instr_valid = (count_q != '0);
  assign pop         = instr_valid && instr_ready && !redirect_valid;
  assign instr       = instr_valid ? fifo_word_q[fifo_head_q] : 32'h0;
  assign instr_pc    = instr_valid ? fifo_pc_q[fifo_head_q]   : 32'h0;

  always_comb begin
    pc_d          = pc_q;
    count_d       = count_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;
    fifo_head_d   = fifo_head_q;
    fifo_tail_d   = fifo_tail_q;
    infl_head_d   = infl_head_q;
    infl_tail_d   = infl_tail_q;

    // Requests and responses are counted regardless of redirects; the
    // in-flight PC queue stays aligned with the memory's response order.
    outstanding_d = outstanding_q + CW'(issue) - CW'(imem_rvalid);
    if (issue)       infl_tail_d = ptr_inc(infl_tail_q);
    if (imem_rvalid) infl_head_d = ptr_inc(infl_head_q);

    if (redirect_valid) begin
      pc_d        = {redirect_pc[31:2], 2'b00};
      count_d     = '0;
      fifo_head_d = '0;
      fifo_tail_d = '0;
      // Everything still in flight after this cycle's response is wrong-path.
      drop_d      = outstanding_q - CW'(imem_rvalid);
    end else begin
      if (issue) pc_d = pc_q + 32'd4;
      if (imem_rvalid && (drop_q != '0)) drop_d = drop_q - CW'(1);
      count_d = count_q + CW'(resp_keep) - CW'(pop);
      if (resp_keep) fifo_tail_d = ptr_inc(fifo_tail_q);
      if (pop)       fifo_head_d = ptr_inc(fifo_head_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      count_q       <= '0;
      outstanding_q <= '0;
      drop_q        <= '0;
      fifo_head_q   <= '0;
      fifo_tail_q   <= '0;
      infl_head_q   <= '0;
      infl_tail_q   <= '0;
    end else begin
      pc_q          <= pc_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      fifo_head_q   <= fifo_head_d;
      fifo_tail_q   <= fifo_tail_d;
      infl_head_q   <= infl_head_d;
      infl_tail_q   <= infl_tail_d;
    end
  end

  // Payload storage needs no reset: outputs are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (issue) infl_pc_q[infl_tail_q] <= pc_q;
    if (resp_keep) begin
      fifo_word_q[fifo_tail_q] <= imem_rdata;
      fifo_pc_q[fifo_tail_q]   <= infl_pc_q[infl_head_q];
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed phases followed by random traffic, every cycle
// compared against a queue-based reference of the fetch stage.
module tb_instr_fetch;

  localparam int unsigned DEPTH = 2;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  // Second instance to check the high RESET_PC wrap
  logic        imem_req2;
  logic [31:0] imem_addr2;
  logic        imem_ready2;
  logic        imem_rvalid2;
  logic        instr_valid2;
  logic [31:0] instr2;
  logic [31:0] instr_pc2;

  instr_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc)
  );

  instr_fetch #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_ready(imem_ready2),
    .imem_rvalid(imem_rvalid2), .imem_rdata(32'h1357_9BDF),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .instr_valid(instr_valid2), .instr_ready(1'b1),
    .instr(instr2), .instr_pc(instr_pc2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: instruction memory contents, buffered words and in-flight requests
  typedef struct packed {logic [31:0] pc; logic wrong;} infl_t;
  typedef struct packed {logic [31:0] word; logic [31:0] pc;} ent_t;

  infl_t       m_infl[$];
  ent_t        m_fifo[$];
  logic [31:0] m_pc;

  logic [31:0] dut_issue[$];
  logic [31:0] dut_pop[$];
  logic [31:0] addrs2[$];

  int          vectors = 0;
  int          miscompares = 0;
  int          ready_pct, rv_pct, ir_pct;
  logic        redir_now;
  logic [31:0] redir_target;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
  endfunction

  function automatic logic [31:0] q_at(input logic [31:0] q[$], input int idx);
    if (idx < q.size()) return q[idx];
    return 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus, checking and model update.
  task automatic cycle();
    logic  exp_req;
    infl_t e;
    @(negedge clk);
    imem_ready     = ($urandom_range(0, 99) < ready_pct);
    imem_rvalid    = (m_infl.size() != 0) && ($urandom_range(0, 99) < rv_pct);
    imem_rdata     = imem_rvalid ? mem_word(m_infl[0].pc) : $urandom;
    instr_ready    = ($urandom_range(0, 99) < ir_pct);
    redirect_valid = redir_now;
    redirect_pc    = redir_target;
    #1;
    exp_req = !redir_now && ((m_fifo.size() + m_infl.size()) < DEPTH);
    chk("imem_req", 32'(imem_req), 32'(exp_req));
    chk("imem_addr", imem_addr, m_pc);
    chk("instr_valid", 32'(instr_valid), 32'(m_fifo.size() != 0));
    if (m_fifo.size() != 0) begin
      chk("instr", instr, m_fifo[0].word);
      chk("instr_pc", instr_pc, m_fifo[0].pc);
    end
    if (imem_req && imem_ready) dut_issue.push_back(imem_addr);
    if (instr_valid && instr_ready && !redirect_valid) dut_pop.push_back(instr_pc);
    @(posedge clk);
    if (!redir_now && (m_fifo.size() != 0) && instr_ready) void'(m_fifo.pop_front());
    if (imem_rvalid) begin
      e = m_infl.pop_front();
      if (!e.wrong && !redir_now) m_fifo.push_back(ent_t'{word: mem_word(e.pc), pc: e.pc});
    end
    if (redir_now) begin
      m_fifo.delete();
      for (int i = 0; i < m_infl.size(); i++) m_infl[i].wrong = 1'b1;
      m_pc = {redir_target[31:2], 2'b00};
    end
    if (exp_req && imem_ready) begin
      m_infl.push_back(infl_t'{pc: m_pc, wrong: 1'b0});
      m_pc = m_pc + 32'd4;
    end
    redir_now = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n          = 1'b0;
    imem_ready     = 1'b0;
    imem_rvalid    = 1'b0;
    redirect_valid = 1'b0;
    instr_ready    = 1'b0;
    #1;
    chk("rst_imem_req", 32'(imem_req), 32'h0);
    chk("rst_imem_addr", imem_addr, 32'h0);
    chk("rst_instr_valid", 32'(instr_valid), 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_instr_pc", instr_pc, 32'h0);
    chk("rst_imem_addr2", imem_addr2, 32'hFFFF_FFF8);
    m_fifo.delete();
    m_infl.delete();
    m_pc = 32'h0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int pend2;
    logic req2_s;
    rst_n = 1'b0; imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; instr_ready = 1'b0;
    imem_ready2 = 1'b0; imem_rvalid2 = 1'b0;
    redir_now = 1'b0; redir_target = 32'h0;
    repeat (2) @(posedge clk);
    do_reset();

    // High reset PC wraps to zero (main instance held idle, model untouched)
    pend2 = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      imem_ready2  = 1'b1;
      imem_rvalid2 = (pend2 > 0);
      #1;
      req2_s = imem_req2;
      if (req2_s) addrs2.push_back(imem_addr2);
      @(posedge clk);
      if (imem_rvalid2) pend2--;
      if (req2_s) pend2++;
    end
    @(negedge clk);
    imem_ready2 = 1'b0; imem_rvalid2 = 1'b0;
    chk("wrap_addr0", q_at(addrs2, 0), 32'hFFFF_FFF8);
    chk("wrap_addr1", q_at(addrs2, 1), 32'hFFFF_FFFC);
    chk("wrap_addr2", q_at(addrs2, 2), 32'h0000_0000);

    // Zero-wait memory, ready decode: sequential addresses
    ready_pct = 100; rv_pct = 100; ir_pct = 100;
    dut_issue.delete(); dut_pop.delete();
    run(12);
    chk("seq_addr0", q_at(dut_issue, 0), 32'h0);
    chk("seq_addr1", q_at(dut_issue, 1), 32'h4);
    chk("seq_addr2", q_at(dut_issue, 2), 32'h8);
    chk("seq_pop0", q_at(dut_pop, 0), 32'h0);

    // Stalled decode: FIFO fills with two words, then drains in order
    do_reset();
    dut_issue.delete(); dut_pop.delete();
    ir_pct = 0;
    run(6);
    chk("full_reqs", 32'(dut_issue.size()), 32'd2);
    dut_issue.delete();
    ir_pct = 100;
    run(6);
    chk("drain_pop0", q_at(dut_pop, 0), 32'h0);
    chk("drain_pop1", q_at(dut_pop, 1), 32'h4);
    chk("resume_addr", q_at(dut_issue, 0), 32'h8);

    // Redirect with two requests in flight
    rv_pct = 0;
    run(4);
    dut_pop.delete();
    redir_now = 1'b1; redir_target = 32'h100;
    cycle();
    rv_pct = 100;
    run(8);
    chk("redir_first_pc", q_at(dut_pop, 0), 32'h100);

    // Misaligned target, response in the redirect cycle
    run(3);
    dut_pop.delete();
    redir_now = 1'b1; redir_target = 32'h103;
    cycle();
    #2;
    chk("redir_align", imem_addr, 32'h100);
    run(8);
    chk("redir_align_pop", q_at(dut_pop, 0), 32'h100);

    // Random traffic with random redirects
    ready_pct = 70; rv_pct = 60; ir_pct = 70;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 99) < 4) begin
        redir_now    = 1'b1;
        redir_target = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                   : $urandom;
      end
      cycle();
    end

    // Reset in mid-operation
    do_reset();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
